// File: rtl/pp_reduce_pkg.sv
// pp_reduce_pkg
//   Shared constants, the carry-save pair type and the row-alignment helper
//   for the Booth partial-product reduction tree.
//   Build option: PP_REDUCE_FINAL_ADD_EN adds a fourth (carry-propagate) stage.
package pp_reduce_pkg;

    localparam int PROD_W   = 48;
    localparam int PP_W     = 26;
    localparam int NUM_PP   = 13;
    localparam int NUM_ROWS = NUM_PP - 2;     // rows carrying a negate-correction bit
    localparam int NUM_VEC  = NUM_PP + 1;     // 13 rows + one merged correction vector
`ifdef PP_REDUCE_FINAL_ADD_EN
    localparam int NUM_STAGES = 4;
`else
    localparam int NUM_STAGES = 3;
`endif

    typedef struct packed {
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
    } cs_pair_t;

    // Correction bit of row i sits at weight 2i; no two rows share a bit
    // position, so all eleven fold into one vector with plain ORs.
    function automatic logic [NUM_VEC-1:0][PROD_W-1:0] align_rows(
        input logic [NUM_ROWS-1:0][PP_W-1:0] pp,
        input logic [24:0]                   pp11,
        input logic [22:0]                   pp12
    );
        logic [NUM_VEC-1:0][PROD_W-1:0] v;
        logic [PROD_W-1:0]              corr;
        v    = '0;
        corr = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            v[i]        = {{(PROD_W-PP_W+1){1'b0}}, pp[i][PP_W-1:1]} << (2*i);
            corr[2*i]   = pp[i][0];
        end
        v[NUM_ROWS]   = corr;
        v[NUM_ROWS+1] = {23'b0, pp11} << 22;
        v[NUM_ROWS+2] = {25'b0, pp12} << 24;
        return v;
    endfunction

endpackage

// File: rtl/pp_reduce_pipe_csa3.sv
// csa3
//   Combinational 3:2 carry-save compressor.
//   i_a, i_b, i_c : operands
//   o_s           : bitwise sum
//   o_c           : majority carry, already shifted to its weight (MSB dropped)
module csa3 #(
    parameter int W = 48
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_s,
    output logic [W-1:0] o_c
);
    logic [W-1:0] w_maj;

    assign w_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_s   = i_a ^ i_b ^ i_c;
    assign o_c   = {w_maj[W-2:0], 1'b0};
endmodule

// File: rtl/pp_reduce_pipe.sv
// pp_reduce_pipe
//   Pipelined carry-save reduction of 13 Booth partial products into a
//   (sum, carry) pair, with valid/ready handshake and full back-pressure.
//   CLK/nRST           : clock, async active-low reset
//   flush              : drop everything in flight (sync)
//   in_valid/in_ready  : input handshake for pp, pp11, pp12
//   out_valid/out_ready: output handshake
//   sum, carry         : carry-save result (default build)
//   product            : sum+carry, registered (PP_REDUCE_FINAL_ADD_EN build)
//   Stages: S1 14->6, S2 6->3, S3 3->2, optional S4 carry-propagate add.
module pp_reduce_pipe
    import pp_reduce_pkg::*;
(
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_ROWS-1:0][PP_W-1:0] pp,
    input  logic [24:0]                  pp11,
    input  logic [22:0]                  pp12,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef PP_REDUCE_FINAL_ADD_EN
    output logic [PROD_W-1:0]            product
`else
    output logic [PROD_W-1:0]            sum,
    output logic [PROD_W-1:0]            carry
`endif
);

    logic [NUM_STAGES-1:0] r_v;
    logic                  w_en1, w_en2, w_en3;
    logic                  w_ld1, w_ld2, w_ld3;

    // A stage may load when empty or when its occupant moves on this cycle;
    // the chain is combinational from out_ready back to in_ready.
`ifdef PP_REDUCE_FINAL_ADD_EN
    logic                  w_en4, w_ld4;
    logic [PROD_W-1:0]     r_prod;
    assign w_en4 = !r_v[3] || out_ready;
    assign w_en3 = !r_v[2] || w_en4;
    assign w_ld4 = w_en4 && r_v[2];
`else
    assign w_en3 = !r_v[2] || out_ready;
`endif
    assign w_en2 = !r_v[1] || w_en3;
    assign w_en1 = !r_v[0] || w_en2;
    assign w_ld1 = w_en1 && in_valid;
    assign w_ld2 = w_en2 && r_v[0];
    assign w_ld3 = w_en3 && r_v[1];

    assign in_ready  = flush || w_en1;
    assign out_valid = r_v[NUM_STAGES-1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_v <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            if (w_en1) r_v[0] <= in_valid;
            if (w_en2) r_v[1] <= r_v[0];
            if (w_en3) r_v[2] <= r_v[1];
`ifdef PP_REDUCE_FINAL_ADD_EN
            if (w_en4) r_v[3] <= r_v[2];
`endif
        end
    end

    // ---------------- S1: 14 -> 10 -> 7 -> 6 ----------------
    logic [NUM_VEC-1:0][PROD_W-1:0] w_rows;
    logic [PROD_W-1:0]              w_la  [10];
    logic [PROD_W-1:0]              w_lb  [7];
    logic [PROD_W-1:0]              w_s1d [6];
    logic [PROD_W-1:0]              r_s1  [6];

    assign w_rows = align_rows(pp, pp11, pp12);

    for (genvar j = 0; j < 4; j++) begin : g_la
        csa3 #(.W(PROD_W)) u_csa (
            .i_a(w_rows[3*j]), .i_b(w_rows[3*j+1]), .i_c(w_rows[3*j+2]),
            .o_s(w_la[2*j]),   .o_c(w_la[2*j+1])
        );
    end
    assign w_la[8] = w_rows[12];
    assign w_la[9] = w_rows[13];

    for (genvar j = 0; j < 3; j++) begin : g_lb
        csa3 #(.W(PROD_W)) u_csa (
            .i_a(w_la[3*j]), .i_b(w_la[3*j+1]), .i_c(w_la[3*j+2]),
            .o_s(w_lb[2*j]), .o_c(w_lb[2*j+1])
        );
    end
    assign w_lb[6] = w_la[9];

    csa3 #(.W(PROD_W)) u_s1_lc (
        .i_a(w_lb[0]), .i_b(w_lb[1]), .i_c(w_lb[2]),
        .o_s(w_s1d[0]), .o_c(w_s1d[1])
    );
    assign w_s1d[2] = w_lb[3];
    assign w_s1d[3] = w_lb[4];
    assign w_s1d[4] = w_lb[5];
    assign w_s1d[5] = w_lb[6];

    // ---------------- S2: 6 -> 4 -> 3 ----------------
    logic [PROD_W-1:0] w_m   [4];
    logic [PROD_W-1:0] w_s2d [3];
    logic [PROD_W-1:0] r_s2  [3];

    csa3 #(.W(PROD_W)) u_s2_a (
        .i_a(r_s1[0]), .i_b(r_s1[1]), .i_c(r_s1[2]), .o_s(w_m[0]), .o_c(w_m[1])
    );
    csa3 #(.W(PROD_W)) u_s2_b (
        .i_a(r_s1[3]), .i_b(r_s1[4]), .i_c(r_s1[5]), .o_s(w_m[2]), .o_c(w_m[3])
    );
    csa3 #(.W(PROD_W)) u_s2_c (
        .i_a(w_m[0]), .i_b(w_m[1]), .i_c(w_m[2]), .o_s(w_s2d[0]), .o_c(w_s2d[1])
    );
    assign w_s2d[2] = w_m[3];

    // ---------------- S3: 3 -> 2 ----------------
    cs_pair_t w_s3d;
    cs_pair_t r_s3;

    csa3 #(.W(PROD_W)) u_s3 (
        .i_a(r_s2[0]), .i_b(r_s2[1]), .i_c(r_s2[2]), .o_s(w_s3d.s), .o_c(w_s3d.c)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 6; i++) r_s1[i] <= '0;
            for (int i = 0; i < 3; i++) r_s2[i] <= '0;
            r_s3 <= '0;
        end else begin
            if (w_ld1) for (int i = 0; i < 6; i++) r_s1[i] <= w_s1d[i];
            if (w_ld2) for (int i = 0; i < 3; i++) r_s2[i] <= w_s2d[i];
            if (w_ld3) r_s3 <= w_s3d;
        end
    end

`ifdef PP_REDUCE_FINAL_ADD_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_prod <= '0;
        end else if (w_ld4) begin
            r_prod <= r_s3.s + r_s3.c;
        end
    end
    assign product = r_prod;
`else
    assign sum   = r_s3.s;
    assign carry = r_s3.c;
`endif

endmodule

// File: tb/tb_pp_reduce_pipe.sv
module tb_pp_reduce_pipe;

    logic              CLK = 1'b0;
    logic              nRST, flush, in_valid, in_ready, out_valid, out_ready;
    logic [10:0][25:0] pp;
    logic [24:0]       pp11;
    logic [22:0]       pp12;
    logic [47:0]       w_res;

`ifdef PP_REDUCE_FINAL_ADD_EN
    localparam int LAT = 4;
    logic [47:0] product;
    assign w_res = product;
`else
    localparam int LAT = 3;
    logic [47:0] sum, carry;
    assign w_res = sum + carry;
`endif

    pp_reduce_pipe dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pp(pp), .pp11(pp11), .pp12(pp12),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef PP_REDUCE_FINAL_ADD_EN
        .product(product)
`else
        .sum(sum), .carry(carry)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0][25:0] pp;
        logic [24:0]       pp11;
        logic [22:0]       pp12;
        logic [47:0]       expv;
    } rec_t;

    rec_t        tbl [12];
    logic [47:0] sb [$];
    logic [47:0] cur_exp, hold;
    bit          stall, rnd;
    int          tests = 0, fails = 0, n_pop = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic rec_t zrec();
        rec_t r;
        r.pp = '0; r.pp11 = '0; r.pp12 = '0; r.expv = '0;
        return r;
    endfunction

    // Weighted sum of the rows, done with ordinary additions.
    function automatic logic [47:0] model(input rec_t r);
        logic [47:0] acc, t;
        acc = '0;
        for (int i = 0; i < 11; i++) begin
            t   = {23'b0, r.pp[i][25:1]} + {47'b0, r.pp[i][0]};
            acc = acc + (t << (2*i));
        end
        acc = acc + ({23'b0, r.pp11} << 22);
        acc = acc + ({25'b0, r.pp12} << 24);
        return acc;
    endfunction

    // Scoreboard: handshakes are decided at the coming rising edge, so they
    // are observed on the falling edge before it.
    always @(negedge CLK) begin
        if (!nRST) begin
            sb.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", {47'b0, out_valid}, 48'd1);
                chk("stall_data", w_res, hold);
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_unexpected: got %h expected none", w_res);
                end else begin
                    chk("sb_data", w_res, sb.pop_front());
                end
            end
            stall = out_valid && !out_ready && !flush;
            hold  = w_res;
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input rec_t r);
        pp = r.pp; pp11 = r.pp11; pp12 = r.pp12; cur_exp = r.expv;
    endtask

    task automatic send(input rec_t r);
        bit fired;
        int g;
        fired = 1'b0;
        g = 0;
        in_valid = 1'b1;
        drive(r);
        while (!fired && g < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge CLK);
            fired = in_ready;
            @(posedge CLK); #1;
            g++;
        end
        in_valid = 1'b0;
        if (!fired) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no in_ready expected accept");
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && g < 100) begin
            @(posedge CLK); #1;
            g++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic lat_check(input rec_t r);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(r);
        @(negedge CLK);
        chk("lat_in_ready", {47'b0, in_ready}, 48'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge CLK);
            chk("lat_out_valid", {47'b0, out_valid}, {47'b0, (k == LAT)});
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] rv;
        int          sent, pop0;
        bit          fire;

        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pp = '0; pp11 = '0; pp12 = '0; cur_exp = '0; rnd = 1'b0;

        for (int k = 0; k < 12; k++) tbl[k] = zrec();
        tbl[0].pp[3]  = 26'h3;          tbl[0].expv = 48'h0000_0000_0080;
        tbl[1].pp12   = 23'h1;          tbl[1].expv = 48'h0000_0100_0000;
        tbl[2].pp12   = 23'h7FFFFF;     tbl[2].expv = 48'h7FFF_FF00_0000;
        for (int i = 0; i < 11; i++) tbl[3].pp[i] = 26'h3FFFFFF;
        tbl[3].pp11   = 25'h1FFFFFF;
        tbl[3].pp12   = 23'h7FFFFF;     tbl[3].expv = 48'h2AAA_A8C0_0000;
        tbl[4].pp[0]  = 26'h3FFFFFF;    tbl[4].expv = 48'h0000_0200_0000;
        tbl[5].pp11   = 25'h1;          tbl[5].expv = 48'h0000_0040_0000;
        tbl[6].pp[10] = 26'h2;          tbl[6].expv = 48'h0000_0010_0000;
        for (int i = 0; i < 11; i++) tbl[7].pp[i] = 26'h1;
        tbl[7].expv = 48'h0000_0015_5555;
        for (int k = 8; k < 12; k++) begin
            for (int i = 0; i < 11; i++) begin
                rv = $urandom();
                tbl[k].pp[i] = rv[25:0];
            end
            rv = $urandom(); tbl[k].pp11 = rv[24:0];
            rv = $urandom(); tbl[k].pp12 = rv[22:0];
            tbl[k].expv = model(tbl[k]);
        end

        // Reset state
        #12;
        chk("rst_out_valid", {47'b0, out_valid}, 48'd0);
        chk("rst_in_ready", {47'b0, in_ready}, 48'd1);
        chk("rst_result", w_res, 48'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        chk("rel_in_ready", {47'b0, in_ready}, 48'd1);
        @(posedge CLK); #1;

        // Table, back-to-back with out_ready high, then with random out_ready
        for (int k = 0; k < 12; k++) send(tbl[k]);
        drain();
        rnd = 1'b1;
        for (int k = 0; k < 12; k++) send(tbl[k]);
        rnd = 1'b0;
        drain();

        // Latency and single-cycle out_valid
        lat_check(tbl[0]);
        lat_check(tbl[2]);

        // Back-pressure: 6 bundles, out_ready low in cycles 4..7
        sent = 0;
        pop0 = n_pop;
        for (int c = 1; c <= 60 && (sent < 6 || sb.size() != 0); c++) begin
            in_valid = (sent < 6);
            if (sent < 6) drive(tbl[sent]);
            out_ready = !(c >= 4 && c <= 7);
            @(negedge CLK);
            if (c >= 4 && c <= 7) chk("bp_in_ready", {47'b0, in_ready}, 48'd0);
            if (c == 4) chk("bp_out_valid", {47'b0, out_valid}, 48'd1);
            fire = in_valid && in_ready;
            @(posedge CLK); #1;
            if (fire) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 48'(sent), 48'd6);
        chk("bp_count", 48'(n_pop - pop0), 48'd6);

        // Flush with two bundles in flight and a third offered
        send(tbl[4]);
        send(tbl[5]);
        flush = 1'b1;
        in_valid = 1'b1;
        drive(tbl[6]);
        @(negedge CLK);
        chk("flush_in_ready", {47'b0, in_ready}, 48'd1);
        @(posedge CLK); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("flush_no_out", {47'b0, out_valid}, 48'd0);
        end
        @(posedge CLK); #1;
        lat_check(tbl[7]);

        // Asynchronous reset mid-stream
        for (int k = 8; k < 12; k++) send(tbl[k]);
        chk("pre_rst_valid", {47'b0, out_valid}, 48'd1);
        nRST = 1'b0;
        #1;
        chk("async_out_valid", {47'b0, out_valid}, 48'd0);
`ifdef PP_REDUCE_FINAL_ADD_EN
        chk("async_product", product, 48'd0);
`else
        chk("async_sum", sum, 48'd0);
        chk("async_carry", carry, 48'd0);
`endif
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", {47'b0, in_ready}, 48'd1);
        chk("post_rst_out_valid", {47'b0, out_valid}, 48'd0);
        @(posedge CLK); #1;
        lat_check(tbl[1]);

        drain();
        chk("sb_empty", 48'(sb.size()), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
